// File: rtl/simple_proc_pkg.sv
// Shared types and constants for the processor program loader and its RAM.
package simple_proc_pkg;

    localparam int unsigned PROG_ADDR_W = 8;
    localparam int unsigned INSTR_W     = 16;

    // The load stream carries the high byte of each word first.
    localparam bit HI_BYTE_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        START,
        RUN
    } loader_state_t;

    function automatic logic [INSTR_W-1:0] pack_word(input logic [7:0] first,
                                                     input logic [7:0] second);
        return HI_BYTE_FIRST ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/simple_proc_prog_loader_ram.sv
// Program memory: single port, synchronous write, registered read with a resettable output register.
module prog_ram_16x256
    import simple_proc_pkg::*;
#(
    parameter int unsigned ADDR_W = PROG_ADDR_W,
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register holds its value when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/simple_proc_prog_loader.sv
// Program loader: fills program RAM from a byte stream, pulses start, then serves fetches.
// Optional macro SIMPLE_PROC_LOADER_CHECKSUM_EN adds a load checksum gate on start.
module simple_proc_prog_loader
    import simple_proc_pkg::*;
#(
    parameter int unsigned ADDR_W = PROG_ADDR_W,
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [7:0]        load_byte,
    input  logic              load_vld,
    output logic              load_rdy,
    input  logic              load_last,
    output logic              start,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ram_read_en,
    output logic [DATA_W-1:0] instr_data,
    output logic              instr_vld,
    output logic [ADDR_W:0]   word_count,
    output logic              running,
`ifdef SIMPLE_PROC_LOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
    input  logic [15:0]       chk_expected,
`endif
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    loader_state_t     state;
    logic [7:0]        hi_byte;
    logic              xfer;
    logic              word_done;
    logic              full;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              chk_ok;
`ifdef SIMPLE_PROC_LOADER_CHECKSUM_EN
    logic [15:0]       chk_next;
`endif

    always_comb begin
        xfer      = load_vld & load_rdy & ~clr;
        word_done = xfer & ((state == LOAD_LO) | load_last);
        full      = (word_count == DEPTH);
        wr_en     = word_done & ~full;
        wr_addr   = word_count[ADDR_W-1:0];
        // A final byte arriving in the high-byte slot is padded with a zero low byte.
        wr_data   = (state == LOAD_LO) ? pack_word(hi_byte, load_byte)
                                       : pack_word(load_byte, 8'h00);
        rd_en     = (state == RUN) & ram_read_en & ~clr;
        ram_addr  = (state == RUN) ? pc : wr_addr;
`ifdef SIMPLE_PROC_LOADER_CHECKSUM_EN
        chk_next  = checksum + (wr_en ? wr_data : '0);
        chk_ok    = (chk_next == chk_expected);
`else
        chk_ok    = 1'b1;
`endif
    end

    prog_ram_16x256 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .re    (rd_en),
        .addr  (ram_addr),
        .wdata (wr_data),
        .rdata (instr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hi_byte    <= '0;
            load_rdy   <= 1'b0;
            start      <= 1'b0;
            instr_vld  <= 1'b0;
            word_count <= '0;
            running    <= 1'b0;
            err        <= 1'b0;
`ifdef SIMPLE_PROC_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else if (clr) begin
            state      <= IDLE;
            hi_byte    <= '0;
            load_rdy   <= 1'b1;
            start      <= 1'b0;
            instr_vld  <= 1'b0;
            word_count <= '0;
            running    <= 1'b0;
            err        <= 1'b0;
`ifdef SIMPLE_PROC_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            start     <= 1'b0;
            instr_vld <= 1'b0;
            if (wr_en) begin
                word_count <= word_count + 1'b1;
`ifdef SIMPLE_PROC_LOADER_CHECKSUM_EN
                checksum   <= chk_next;
`endif
            end
            if (word_done && full) begin
                err <= 1'b1;
            end
            case (state)
                IDLE, LOAD_HI: begin
                    load_rdy <= 1'b1;
                    if (xfer) begin
                        hi_byte <= load_byte;
                        if (load_last) begin
                            err      <= 1'b1;
                            state    <= START;
                            load_rdy <= 1'b0;
                            start    <= chk_ok;
                        end else begin
                            state <= LOAD_LO;
                        end
                    end
                end
                LOAD_LO: begin
                    if (xfer) begin
                        if (load_last) begin
                            state    <= START;
                            load_rdy <= 1'b0;
                            start    <= chk_ok;
                        end else begin
                            state <= LOAD_HI;
                        end
                    end
                end
                START: begin
`ifdef SIMPLE_PROC_LOADER_CHECKSUM_EN
                    if (checksum != chk_expected) begin
                        state    <= IDLE;
                        err      <= 1'b1;
                        load_rdy <= 1'b1;
                    end else begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
`else
                    state   <= RUN;
                    running <= 1'b1;
`endif
                end
                RUN: begin
                    running   <= 1'b1;
                    instr_vld <= ram_read_en;
                end
                default: begin
                    state    <= IDLE;
                    load_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule
